// File: rtl/pixel_plot_sink.sv
// Pixel-draw sink: FIFO-buffered {x,y} -> linear framebuffer writes plus a full-screen clear engine.
// Optional `PLOT_COLOUR_KEY_EN: pixels in KEY_COLOUR are consumed without a write.
module pixel_plot_sink #(
    parameter int         FIFO_DEPTH   = 8,
    parameter int         SCREEN_W     = 160,
    parameter int         SCREEN_H     = 120,
    parameter logic [8:0] CLEAR_COLOUR = 9'h000,
    parameter logic [8:0] KEY_COLOUR   = 9'h1C7
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic [8:0]  colour,
    input  logic [14:0] coordinates,
    output logic        ready,
    input  logic        clear_req,
    output logic        clear_busy,
    input  logic        fb_stall,
    output logic        fb_wren,
    output logic [14:0] fb_addr,
    output logic [8:0]  fb_data,
    output logic [7:0]  drop_count,
    output logic        idle
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [14:0] LAST_ADDR = 15'(SCREEN_W * SCREEN_H - 1);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    logic [1:0]  state;
    logic [23:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, fifo_count;
    logic        empty, full, push, pop;
    logic [23:0] head;
    logic [7:0]  head_x;
    logic [6:0]  head_y;
    logic [8:0]  head_col;
    logic        in_range, keyed;
    logic [14:0] head_addr;
    logic [14:0] clr_addr;
    logic        wr_q;

    assign fifo_count = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign ready      = resetn && !full && (state == S_RUN);
    assign push       = valid && ready;
    assign pop        = !empty && !fb_stall && (state != S_CLEAR);

    assign head     = mem[rd_ptr[AW-1:0]];
    assign head_col = head[23:15];
    assign head_x   = head[14:7];
    assign head_y   = head[6:0];
    assign in_range = (32'(head_x) < SCREEN_W) && (32'(head_y) < SCREEN_H);
    // y*160 as two shifts; only valid for the 160-wide screen
    assign head_addr = ({8'd0, head_y} << 7) + ({8'd0, head_y} << 5) + {7'd0, head_x};

`ifdef PLOT_COLOUR_KEY_EN
    assign keyed = (head_col == KEY_COLOUR);
`else
    assign keyed = 1'b0;
`endif

    // The output register holds a pending write while the port is stalled
    assign fb_wren    = wr_q && !fb_stall;
    assign clear_busy = (state != S_RUN);
    assign idle       = (state == S_RUN) && empty && !wr_q;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {colour, coordinates};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_RUN;
            wr_q       <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            drop_count <= '0;
            clr_addr   <= '0;
        end else begin
            if (!fb_stall) begin
                wr_q <= 1'b0;
                if (state == S_CLEAR) begin
                    if (clr_addr <= LAST_ADDR) begin
                        wr_q     <= 1'b1;
                        fb_addr  <= clr_addr;
                        fb_data  <= CLEAR_COLOUR;
                        clr_addr <= clr_addr + 1'b1;
                    end
                end else if (pop) begin
                    if (!in_range) begin
                        if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
                    end else if (!keyed) begin
                        wr_q    <= 1'b1;
                        fb_addr <= head_addr;
                        fb_data <= head_col;
                    end
                end
            end
            case (state)
                S_RUN:   if (clear_req) state <= S_DRAIN;
                S_DRAIN: if (empty && !wr_q) begin
                    state    <= S_CLEAR;
                    clr_addr <= '0;
                end
                S_CLEAR: if (!fb_stall && wr_q && fb_addr == LAST_ADDR) state <= S_RUN;
                default: state <= S_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_plot_sink.sv
// Scoreboard bench for pixel_plot_sink: stimulus pushes expected writes, a monitor pops and compares.
module tb_pixel_plot_sink;
    logic        clk = 1'b0, resetn = 1'b0, valid = 1'b0, clear_req = 1'b0, fb_stall = 1'b0;
    logic [8:0]  colour = '0;
    logic [14:0] coordinates = '0;
    logic        ready, clear_busy, fb_wren, idle;
    logic [14:0] fb_addr;
    logic [8:0]  fb_data;
    logic [7:0]  drop_count;

    pixel_plot_sink dut (
        .clk(clk), .resetn(resetn), .valid(valid), .colour(colour),
        .coordinates(coordinates), .ready(ready), .clear_req(clear_req),
        .clear_busy(clear_busy), .fb_stall(fb_stall), .fb_wren(fb_wren),
        .fb_addr(fb_addr), .fb_data(fb_data), .drop_count(drop_count), .idle(idle)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_wr = 0, exp_drop = 0;
    logic [23:0] q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: screen rules applied to an accepted pixel
    task automatic model_push(input int x, input int y, input logic [8:0] c);
        bit transparent = 1'b0;
`ifdef PLOT_COLOUR_KEY_EN
        transparent = (c == 9'h1C7);
`endif
        if (x >= 160 || y >= 120) begin
            if (exp_drop < 255) exp_drop++;
        end else if (!transparent) begin
            q.push_back({15'(y * 160 + x), c});
        end
    endtask

    task automatic expect_clear();
        for (int a = 0; a < 19200; a++) q.push_back({15'(a), 9'h000});
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance
    task automatic send(input int x, input int y, input logic [8:0] c);
        int t = 0;
        valid = 1'b1; colour = c; coordinates = {8'(x), 7'(y)};
        while (!ready && t < 50000) begin
            fb_stall = 1'b0;
            @(negedge clk); t++;
        end
        if (!ready) chk("send_timeout", 0, 1);
        else begin
            model_push(x, y, c);
            @(negedge clk);
        end
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int t = 0;
        while (!(idle && q.size() == 0) && t < max) begin @(negedge clk); t++; end
        chk("wait_idle", int'(idle && q.size() == 0), 1);
    endtask

    always @(negedge clk) begin
        #1;
        if (resetn) begin
            if (fb_stall) chk("wren_during_stall", int'(fb_wren), 0);
            if (clear_busy) chk("ready_while_busy", int'(ready), 0);
            if (fb_wren) begin
                n_wr++;
                if (q.size() == 0) chk("unexpected_write", int'(fb_addr), -1);
                else begin
                    logic [23:0] e;
                    e = q.pop_front();
                    chk("wr_addr", int'(fb_addr), int'(e[23:9]));
                    chk("wr_data", int'(fb_data), int'(e[8:0]));
                end
            end
        end
    end

    initial begin
        int t, w0;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(ready), 0);
        chk("rst_wren", int'(fb_wren), 0);
        chk("rst_addr", int'(fb_addr), 0);
        chk("rst_data", int'(fb_data), 0);
        chk("rst_drop", int'(drop_count), 0);
        chk("rst_busy", int'(clear_busy), 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_idle", int'(idle), 1);
        chk("rst_ready_rel", int'(ready), 1);

        // single pixel latency
        send(5, 3, 9'h1FF);
        chk("lat_n1_wren", int'(fb_wren), 0);
        @(negedge clk);
        chk("lat_n2_wren", int'(fb_wren), 1);
        chk("lat_addr", int'(fb_addr), 485);
        chk("lat_data", int'(fb_data), 9'h1FF);
        wait_idle(20);

        // stall fills FIFO, release drains back to back
        fb_stall = 1'b1;
        for (int i = 0; i < 8; i++) send(i * 7, i * 3 + 1, 9'(i * 37 + 5));
        chk("full_ready", int'(ready), 0);
        w0 = n_wr;
        fb_stall = 1'b0;
        @(negedge clk);
        chk("ready_after_pop", int'(ready), 1);
        repeat (7) @(negedge clk);
        #2;
        chk("burst_writes", n_wr - w0, 8);
        wait_idle(20);

        // out-of-range drops and saturation
        send(160, 0, 9'h055);
        wait_idle(20);
        chk("drop_one", int'(drop_count), exp_drop);
        send(0, 120, 9'h055);
        wait_idle(20);
        chk("drop_y", int'(drop_count), exp_drop);
        for (int i = 0; i < 300; i++) send(200, i % 128, 9'h0AA);
        wait_idle(20);
        chk("drop_sat", int'(drop_count), 255);

        // key colour pixel
        send(10, 10, 9'h1C7);
        wait_idle(20);
        chk("key_drop", int'(drop_count), exp_drop);

        // randomized traffic with random stalls
        for (int i = 0; i < 300; i++) begin
            fb_stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) != 0)
                send($urandom_range(0, 175), $urandom_range(0, 127), 9'($urandom));
            else
                @(negedge clk);
        end
        fb_stall = 1'b0;
        wait_idle(50);
        chk("rand_drop", int'(drop_count), exp_drop);

        // queued pixels then clear
        fb_stall = 1'b1;
        send(1, 1, 9'h011);
        send(159, 119, 9'h022);
        send(80, 60, 9'h033);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        chk("clr_busy", int'(clear_busy), 1);
        chk("clr_ready", int'(ready), 0);
        expect_clear();
        fb_stall = 1'b0;
        wait_idle(25000);
        chk("clr_done_busy", int'(clear_busy), 0);

        // reset in the middle of a clear
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        expect_clear();
        t = 0;
        while (!(fb_wren && fb_addr == 15'd5000) && t < 25000) begin @(negedge clk); t++; end
        chk("reach_5000", int'(fb_wren && fb_addr == 15'd5000), 1);
        #3 resetn = 1'b0;
        #1;
        chk("abort_wren", int'(fb_wren), 0);
        chk("abort_busy", int'(clear_busy), 0);
        q.delete();
        exp_drop = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("abort_idle", int'(idle), 1);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        expect_clear();
        wait_idle(25000);
        chk("final_q_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
